// File: rtl/bounce_pkg.sv
// Shared types and constants for the contact-bounce emulator.
package bounce_pkg;

    typedef enum logic [1:0] {
        ST_UP        = 2'd0,
        ST_BOUNCE_DN = 2'd1,
        ST_DOWN      = 2'd2,
        ST_BOUNCE_UP = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One right-shifting Galois step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, reloaded with the seed on reset.
module lfsr16
    import bounce_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = lfsr_step(q_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bounce_gen.sv
// Emulates an active-low push button whose contacts bounce for a fixed window
// after each press/release, with pseudo-random dwell between bounce edges.
module bounce_gen
    import bounce_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 64,
    parameter int unsigned TOGGLE_MAX    = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press,
    input  logic       bounce_en,
    output logic       noisy_n,
    output logic       settled,
    output logic [7:0] edge_count
);

    localparam int unsigned WIN_W   = 16;
    localparam int unsigned DWELL_W = 8;
    localparam int unsigned CNT_W   = 8;

    state_e             state_q, state_d;
    logic               noisy_q, noisy_d;
    logic               settled_q, settled_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic [15:0]        lfsr_q;
    logic [DWELL_W-1:0] fresh_dwell;
    logic [CNT_W-1:0]   edge_inc;
    logic               tgt_lvl;
    state_e             tgt_state;
    logic               unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:7];
    assign fresh_dwell = DWELL_W'(lfsr_q[6:0] & 7'(TOGGLE_MAX - 1)) + DWELL_W'(1);
    assign edge_inc    = (edge_q == {CNT_W{1'b1}}) ? edge_q : edge_q + CNT_W'(1);

    // Next-state and output logic; the level change on a press decision is
    // applied in the same cycle the new state becomes visible.
    always_comb begin
        state_d   = state_q;
        noisy_d   = noisy_q;
        settled_d = settled_q;
        edge_d    = edge_q;
        win_d     = win_q;
        dwell_d   = dwell_q;
        tgt_lvl   = (state_q == ST_BOUNCE_UP);
        tgt_state = (state_q == ST_BOUNCE_UP) ? ST_UP : ST_DOWN;

        case (state_q)
            ST_UP: begin
                if (press) begin
                    noisy_d = 1'b0;
                    edge_d  = CNT_W'(1);
                    if (bounce_en) begin
                        state_d   = ST_BOUNCE_DN;
                        settled_d = 1'b0;
                        win_d     = WIN_W'(BOUNCE_CYCLES - 1);
                        dwell_d   = fresh_dwell;
                    end else begin
                        state_d = ST_DOWN;
                    end
                end
            end
            ST_DOWN: begin
                if (!press) begin
                    noisy_d = 1'b1;
                    edge_d  = CNT_W'(1);
                    if (bounce_en) begin
                        state_d   = ST_BOUNCE_UP;
                        settled_d = 1'b0;
                        win_d     = WIN_W'(BOUNCE_CYCLES - 1);
                        dwell_d   = fresh_dwell;
                    end else begin
                        state_d = ST_UP;
                    end
                end
            end
            ST_BOUNCE_DN, ST_BOUNCE_UP: begin
                if (win_q == '0) begin
                    state_d   = tgt_state;
                    settled_d = 1'b1;
                    noisy_d   = tgt_lvl;
                    if (noisy_q != tgt_lvl) begin
                        edge_d = edge_inc;
                    end
                end else begin
                    win_d = win_q - WIN_W'(1);
                    if (dwell_q == DWELL_W'(1)) begin
                        noisy_d = ~noisy_q;
                        edge_d  = edge_inc;
                        dwell_d = fresh_dwell;
                    end else begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_UP;
            noisy_q   <= 1'b1;
            settled_q <= 1'b1;
            edge_q    <= '0;
            win_q     <= '0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            noisy_q   <= noisy_d;
            settled_q <= settled_d;
            edge_q    <= edge_d;
            win_q     <= win_d;
            dwell_q   <= dwell_d;
        end
    end

    assign noisy_n    = noisy_q;
    assign settled    = settled_q;
    assign edge_count = edge_q;

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 64: length of each bounce window in clk cycles, legal range 2..65535.
REQ-002 Parameter TOGGLE_MAX, default 8: maximum dwell between bounce edges; power of two, 1..128.
REQ-003 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; nonzero.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 press  input  1  clean, synchronous press command (1 = button held).
REQ-007 bounce_en  input  1  1 = emulate contact bounce, 0 = clean transitions.
REQ-008 noisy_n  output  1  emulated active-low button line, registered.
REQ-009 settled  output  1  high while the line is in a stable state.
REQ-010 edge_count  output  8  number of noisy_n edges in the most recent transition, saturating.

Function
REQ-011 FSM states SHALL be UP (released), BOUNCE_DN, DOWN (held), BOUNCE_UP.
REQ-012 UP: noisy_n=1; press=1 sampled at cycle t -> BOUNCE_DN at t+1.
REQ-013 DOWN: noisy_n=0; press=0 sampled at cycle t -> BOUNCE_UP at t+1.
REQ-014 On bounce-state entry: noisy_n toggles in the same cycle; edge_count loads 1; window counter loads BOUNCE_CYCLES-1; dwell counter loads a fresh dwell.
REQ-015 Dwell = (lfsr[6:0] & (TOGGLE_MAX-1)) + 1, giving 1..TOGGLE_MAX cycles.
REQ-016 While in a bounce state:
  - the dwell counter decrements each cycle;
  - at expiry noisy_n toggles, edge_count increments (saturating at 255) and the dwell reloads.
REQ-017 When the window counter reaches 0, noisy_n is forced to the target level (0 for BOUNCE_DN, 1 for BOUNCE_UP) and the FSM enters DOWN/UP. If the force changes the level, edge_count increments.
REQ-018 Stable-state entry therefore occurs exactly BOUNCE_CYCLES cycles after bounce entry, and edge_count is odd unless saturated.
REQ-019 press changes during a bounce window are ignored; press is re-evaluated in the first stable cycle, so a stable state lasts at least 1 cycle.
REQ-020 settled = 1 in UP/DOWN and 0 in bounce states, registered coincident with the state.
REQ-021 bounce_en=0 sampled in UP/DOWN with a press change -> go directly to DOWN/UP next cycle: noisy_n = ~press with 1-cycle latency, edge_count=1, settled stays 1.
REQ-022 bounce_en changes mid-window do not affect the current window.
REQ-023 The LFSR is a 16-bit Galois LFSR with taps 16'hB400, advancing every non-reset cycle regardless of state.

Reset
REQ-024 reset=1 at a clock edge, from any state including mid-bounce, gives at the next cycle:
  - state UP, noisy_n=1, settled=1, edge_count=0;
  - counters 0, lfsr=LFSR_SEED.
REQ-025 press sampled high on the first post-reset cycle starts BOUNCE_DN on the following cycle.

Structure
REQ-026 Package bounce_pkg holds the state enum type and the LFSR tap constant (16'hB400).
REQ-027 The LFSR is a sub-module lfsr16 (ports: clk, reset, seed, q[15:0]); the FSM, counters and outputs reside in bounce_gen.

Verification (BOUNCE_CYCLES=64, TOGGLE_MAX=8, seed 16'hACE1)
REQ-028 Reset, press=0 -> noisy_n=1, settled=1, edge_count=0 and held for 100 cycles.
REQ-029 press rises at cycle t, bounce_en=1 -> noisy_n=0 at t+1; settled=0 for t+1..t+64; noisy_n=0 and settled=1 at t+65; edge_count odd; gap between successive edges 1..8 cycles.
REQ-030 press pulsed high for 3 cycles from UP -> full 64-cycle BOUNCE_DN, DOWN for 1 cycle, then BOUNCE_UP; noisy_n=1 and settled=1 at t+130.
REQ-031 bounce_en=0, press toggles at t and t+5 -> noisy_n falls at t+1 and rises at t+6; edge_count=1; settled never 0.
REQ-032 reset asserted 20 cycles into BOUNCE_DN -> next cycle noisy_n=1, state UP, edge_count=0.
REQ-033 Two runs with identical stimulus and seed -> identical noisy_n waveforms, cycle for cycle; a run with seed 16'h0001 -> different edge timing.
